// File: rtl/mem_commit_unit.sv
// rtl/mem_commit_unit.sv - MEM-stage commit: HI/LO, LL bit, CP0 exception/ERET capture and flush sequencing
module mem_commit_unit #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [4:0]  NO_EXC       = 5'h1f
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_stall,
  input  logic [31:0] i_MEM_current_pc,
  input  logic        i_MEM_current_is_in_delay_slot,
  input  logic        i_MEM_is_eret,
  input  logic [4:0]  i_MEM_CP0_except_cause,
  input  logic        i_MEM_RegHi_we,
  input  logic        i_MEM_RegLo_we,
  input  logic [1:0]  i_MEM_LoHi_wdata_selection,
  input  logic [31:0] i_MEM_Mult_hi,
  input  logic [31:0] i_MEM_Mult_lo,
  input  logic [31:0] i_MEM_Div_quotient,
  input  logic [31:0] i_MEM_Div_remainder,
  input  logic [31:0] i_MEM_opr2_value,
  input  logic        i_MEM_LL_set,
  input  logic        i_MEM_LL_bit_value,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_LL_bit,
  output logic [31:0] o_EPC,
  output logic [4:0]  o_cause,
  output logic        o_BD,
  output logic        o_EXL,
  output logic        o_flush,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        ll_q, ll_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  cause_q, cause_d;
  logic        bd_q, bd_d;
  logic        exl_q, exl_d;
  logic        flush_q, flush_d;
  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  logic        commit;
  logic        exc_commit;
  logic        eret_commit;
  logic        normal_commit;
  logic [31:0] hi_src;
  logic [31:0] lo_src;
  logic        hilo_hold;

  assign commit        = (state_q == ST_RUN) && !i_stall;
  assign exc_commit    = commit && (i_MEM_CP0_except_cause != NO_EXC);
  assign normal_commit = commit && (i_MEM_CP0_except_cause == NO_EXC);
  assign eret_commit   = normal_commit && i_MEM_is_eret;

  // Divide places the remainder in HI and the quotient in LO.
  always_comb begin
    hi_src    = hi_q;
    lo_src    = lo_q;
    hilo_hold = 1'b0;
    case (i_MEM_LoHi_wdata_selection)
      2'b00: begin
        hi_src = i_MEM_Mult_hi;
        lo_src = i_MEM_Mult_lo;
      end
      2'b01: begin
        hi_src = i_MEM_Div_remainder;
        lo_src = i_MEM_Div_quotient;
      end
      2'b10: begin
        hi_src = i_MEM_opr2_value;
        lo_src = i_MEM_opr2_value;
      end
      default: hilo_hold = 1'b1;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    ll_d          = ll_q;
    epc_d         = epc_q;
    cause_d       = cause_q;
    bd_d          = bd_q;
    exl_d         = exl_q;
    flush_d       = flush_q;
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;

    if (normal_commit && !hilo_hold) begin
      if (i_MEM_RegHi_we) hi_d = hi_src;
      if (i_MEM_RegLo_we) lo_d = lo_src;
    end

    if (exc_commit || eret_commit) begin
      ll_d = 1'b0;
    end else if (normal_commit) begin
      ll_d = i_MEM_LL_set ? 1'b1 : i_MEM_LL_bit_value;
    end

    // A nested exception keeps the EPC/BD of the outermost one.
    if (exc_commit) begin
      cause_d = i_MEM_CP0_except_cause;
      if (!exl_q) begin
        epc_d = i_MEM_current_is_in_delay_slot ? (i_MEM_current_pc - 32'd4)
                                               : i_MEM_current_pc;
        bd_d  = i_MEM_current_is_in_delay_slot;
      end
      exl_d = 1'b1;
    end else if (eret_commit) begin
      exl_d = 1'b0;
    end

    case (state_q)
      ST_RUN: begin
        if (exc_commit || eret_commit) begin
          state_d       = ST_FLUSH;
          cnt_d         = CNT_INIT;
          flush_d       = 1'b1;
          redir_valid_d = 1'b1;
          redir_pc_d    = exc_commit ? EXC_VECTOR : epc_q;
        end
      end
      default: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RUN;
          flush_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_RUN;
      cnt_q         <= 4'd0;
      hi_q          <= 32'd0;
      lo_q          <= 32'd0;
      ll_q          <= 1'b0;
      epc_q         <= 32'd0;
      cause_q       <= NO_EXC;
      bd_q          <= 1'b0;
      exl_q         <= 1'b0;
      flush_q       <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      ll_q          <= ll_d;
      epc_q         <= epc_d;
      cause_q       <= cause_d;
      bd_q          <= bd_d;
      exl_q         <= exl_d;
      flush_q       <= flush_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign o_hi             = hi_q;
  assign o_lo             = lo_q;
  assign o_LL_bit         = ll_q;
  assign o_EPC            = epc_q;
  assign o_cause          = cause_q;
  assign o_BD             = bd_q;
  assign o_EXL            = exl_q;
  assign o_flush          = flush_q;
  assign o_redirect_valid = redir_valid_q;
  assign o_redirect_pc    = redir_pc_q;

endmodule

// File: tb/tb_mem_commit_unit.sv
// tb/tb_mem_commit_unit.sv - scoreboard bench for mem_commit_unit
module tb_mem_commit_unit;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam logic [4:0]  NOX = 5'h1f;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_stall;
  logic [31:0] i_pc;
  logic        i_ds;
  logic        i_eret;
  logic [4:0]  i_cause;
  logic        i_hi_we, i_lo_we;
  logic [1:0]  i_sel;
  logic [31:0] i_mhi, i_mlo, i_q, i_r, i_opr2;
  logic        i_ll_set, i_ll_val;
  logic [31:0] o_hi, o_lo, o_EPC, o_redirect_pc;
  logic        o_LL_bit, o_BD, o_EXL, o_flush, o_redirect_valid;
  logic [4:0]  o_cause;

  always #5 clk = ~clk;

  mem_commit_unit dut (
    .clk                            (clk),
    .resetn                         (resetn),
    .i_stall                        (i_stall),
    .i_MEM_current_pc               (i_pc),
    .i_MEM_current_is_in_delay_slot (i_ds),
    .i_MEM_is_eret                  (i_eret),
    .i_MEM_CP0_except_cause         (i_cause),
    .i_MEM_RegHi_we                 (i_hi_we),
    .i_MEM_RegLo_we                 (i_lo_we),
    .i_MEM_LoHi_wdata_selection     (i_sel),
    .i_MEM_Mult_hi                  (i_mhi),
    .i_MEM_Mult_lo                  (i_mlo),
    .i_MEM_Div_quotient             (i_q),
    .i_MEM_Div_remainder            (i_r),
    .i_MEM_opr2_value               (i_opr2),
    .i_MEM_LL_set                   (i_ll_set),
    .i_MEM_LL_bit_value             (i_ll_val),
    .o_hi                           (o_hi),
    .o_lo                           (o_lo),
    .o_LL_bit                       (o_LL_bit),
    .o_EPC                          (o_EPC),
    .o_cause                        (o_cause),
    .o_BD                           (o_BD),
    .o_EXL                          (o_EXL),
    .o_flush                        (o_flush),
    .o_redirect_valid               (o_redirect_valid),
    .o_redirect_pc                  (o_redirect_pc)
  );

  typedef struct {
    logic [31:0] hi, lo, epc, rpc;
    logic [4:0]  cause;
    logic        ll, bd, exl, flush, rv;
  } exp_t;

  exp_t m;
  int   m_rem;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare(input exp_t e);
    check("hi", o_hi, e.hi);
    check("lo", o_lo, e.lo);
    check("ll", 32'(o_LL_bit), 32'(e.ll));
    check("epc", o_EPC, e.epc);
    check("cause", 32'(o_cause), 32'(e.cause));
    check("bd", 32'(o_BD), 32'(e.bd));
    check("exl", 32'(o_EXL), 32'(e.exl));
    check("flush", 32'(o_flush), 32'(e.flush));
    check("rv", 32'(o_redirect_valid), 32'(e.rv));
    check("rpc", o_redirect_pc, e.rpc);
  endtask

  task automatic model_reset();
    m.hi = 0; m.lo = 0; m.epc = 0; m.rpc = 0; m.cause = NOX;
    m.ll = 0; m.bd = 0; m.exl = 0; m.flush = 0; m.rv = 0;
    m_rem = 0;
  endtask

  task automatic idle();
    i_stall = 0; i_pc = 32'h8000_0000; i_ds = 0; i_eret = 0; i_cause = NOX;
    i_hi_we = 0; i_lo_we = 0; i_sel = 2'b11;
    i_mhi = 0; i_mlo = 0; i_q = 0; i_r = 0; i_opr2 = 0;
    i_ll_set = 0; i_ll_val = 0;
  endtask

  // Predict the next state from the inputs now applied, then clock and compare.
  task automatic step();
    exp_t e;
    exp_t got;
    e = m;
    e.rv = 0;
    if (m_rem > 0) begin
      m_rem--;
      e.flush = (m_rem > 0);
    end else if (!i_stall) begin
      if (i_cause != NOX) begin
        e.cause = i_cause;
        if (!m.exl) begin
          e.epc = i_ds ? i_pc - 32'd4 : i_pc;
          e.bd  = i_ds;
        end
        e.exl = 1; e.ll = 0;
        e.rv = 1; e.rpc = VEC; e.flush = 1; m_rem = 2;
      end else begin
        if (i_hi_we)
          e.hi = (i_sel == 2'b00) ? i_mhi : (i_sel == 2'b01) ? i_r : (i_sel == 2'b10) ? i_opr2 : m.hi;
        if (i_lo_we)
          e.lo = (i_sel == 2'b00) ? i_mlo : (i_sel == 2'b01) ? i_q : (i_sel == 2'b10) ? i_opr2 : m.lo;
        if (i_eret) begin
          e.exl = 0; e.ll = 0;
          e.rv = 1; e.rpc = m.epc; e.flush = 1; m_rem = 2;
        end else begin
          e.ll = i_ll_set ? 1'b1 : i_ll_val;
        end
      end
    end
    sb.push_back(e);
    m = e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      compare(got);
    end
  endtask

  initial begin
    resetn = 0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare(m);
    check("rst_cause", 32'(o_cause), 32'h1f);
    resetn = 1;

    // Multiply write
    i_sel = 2'b00; i_hi_we = 1; i_lo_we = 1; i_mhi = 32'h1; i_mlo = 32'h2;
    step();
    check("mult_hi", o_hi, 32'h1);
    check("mult_lo", o_lo, 32'h2);

    // Divide, LO only
    idle(); i_sel = 2'b01; i_lo_we = 1; i_q = 7; i_r = 3;
    step();
    check("div_lo", o_lo, 32'd7);
    check("div_hi_kept", o_hi, 32'h1);

    // MTHI
    idle(); i_sel = 2'b10; i_hi_we = 1; i_opr2 = 32'hDEAD_BEEF;
    step();
    check("mthi", o_hi, 32'hDEAD_BEEF);
    check("mthi_lo_kept", o_lo, 32'd7);

    // Exception in delay slot, HI/LO writes suppressed
    idle(); i_pc = 32'h8000_0104; i_cause = 5'h0c; i_ds = 1;
    i_sel = 2'b00; i_hi_we = 1; i_lo_we = 1; i_mhi = 32'h55; i_mlo = 32'h66;
    step();
    check("exc_epc", o_EPC, 32'h8000_0100);
    check("exc_bd", 32'(o_BD), 32'd1);
    check("exc_rv", 32'(o_redirect_valid), 32'd1);
    check("exc_rpc", o_redirect_pc, 32'hBFC0_0380);
    check("exc_hi", o_hi, 32'hDEAD_BEEF);
    idle(); i_cause = 5'h04; i_pc = 32'h8000_0500;
    step();
    check("flush2", 32'(o_flush), 32'd1);
    check("rv_once", 32'(o_redirect_valid), 32'd0);
    check("ignored_cause", 32'(o_cause), 32'h0c);
    step();
    check("flush_end", 32'(o_flush), 32'd0);
    idle();

    // Nested exception keeps EPC
    i_pc = 32'h8000_0200; i_cause = 5'h0d;
    step();
    check("nest_cause", 32'(o_cause), 32'h0d);
    check("nest_epc", o_EPC, 32'h8000_0100);
    check("nest_rpc", o_redirect_pc, 32'hBFC0_0380);
    idle(); step(); step();

    // LL then ERET
    i_ll_set = 1;
    step();
    check("ll_set", 32'(o_LL_bit), 32'd1);
    idle(); i_eret = 1; i_ll_val = 1;
    step();
    check("eret_rpc", o_redirect_pc, 32'h8000_0100);
    check("eret_exl", 32'(o_EXL), 32'd0);
    check("eret_ll", 32'(o_LL_bit), 32'd0);
    idle(); step();
    check("eret_flush2", 32'(o_flush), 32'd1);
    step();
    check("eret_flush_end", 32'(o_flush), 32'd0);

    // Stall blocks exception capture
    i_stall = 1; i_cause = 5'h0c; i_pc = 32'h8000_0300;
    step();
    check("stall_exl", 32'(o_EXL), 32'd0);
    check("stall_rv", 32'(o_redirect_valid), 32'd0);

    // ERET and exception together: exception wins
    idle(); i_eret = 1; i_cause = 5'h0c; i_pc = 32'h8000_0300;
    step();
    check("prio_exl", 32'(o_EXL), 32'd1);
    check("prio_rpc", o_redirect_pc, 32'hBFC0_0380);
    check("prio_epc", o_EPC, 32'h8000_0300);

    // Reset during flush cycle 1
    idle();
    resetn = 0;
    #1;
    model_reset();
    check("rst_flush", 32'(o_flush), 32'd0);
    compare(m);
    @(posedge clk);
    #1;
    resetn = 1;

    // pc-4 wraps at zero
    i_pc = 32'h0; i_ds = 1; i_cause = 5'h05;
    step();
    check("wrap_epc", o_EPC, 32'hFFFF_FFFC);
    idle(); step(); step();

    // Random mix
    for (int k = 0; k < 60; k++) begin
      i_stall  = ($urandom_range(0, 3) == 0);
      i_pc     = $urandom & 32'hFFFF_FFFC;
      i_ds     = $urandom_range(0, 1);
      i_eret   = ($urandom_range(0, 7) == 0);
      i_cause  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 30)) : NOX;
      i_hi_we  = $urandom_range(0, 1);
      i_lo_we  = $urandom_range(0, 1);
      i_sel    = 2'($urandom_range(0, 3));
      i_mhi    = $urandom; i_mlo = $urandom; i_q = $urandom; i_r = $urandom;
      i_opr2   = $urandom;
      i_ll_set = $urandom_range(0, 1);
      i_ll_val = $urandom_range(0, 1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
